// File: rtl/sram_pkg.sv
// ============================================================================
// Module      : sram_pkg
// Description : Shared definitions for the 32-bit to 16-bit SRAM bridge:
//               state encoding, SRAM geometry, data-window base address and
//               a helper that sizes the per-half cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

    // Byte address where the data-memory window begins.
    localparam int SRAM_BASE_ADDR = 1024;
    // 16-bit word address width of the external SRAM.
    localparam int SRAM_ADDR_W    = 18;
    // External data bus width.
    localparam int SRAM_DATA_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    // Bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_cycle_counter.sv
// ============================================================================
// Module      : sram_cycle_counter
// Description : Loadable down-counter that times each SRAM half access.
//               Stops at zero; o_zero marks the last cycle of a half.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_load        - load i_load_val (has priority over i_dec)
//               i_load_val    - value loaded (half length minus one)
//               i_dec         - decrement when non-zero
//               o_zero        - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_cycle_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/sram_controller.sv
// ============================================================================
// Module      : sram_controller
// Description : Bridges 32-bit MEM-stage word reads/writes onto a 16-bit
//               asynchronous SRAM as two half accesses (low half, then high
//               half). readyOut low freezes the pipeline while busy.
// Ports       : clk, rst                 - clock, sync active-high reset
//               memReadIn, memWriteIn    - word request (both high = write)
//               addrIn, writeDataIn      - byte address / write word
//               readDataOut              - last completed read word
//               readyOut                 - 0 while an access is pending
//               sramAddr, sramDq, sramWeN- SRAM address, data, write enable
//               sramUbN/LbN/CeN/OeN      - tied active (0)
// Config      : SRAM_WAIT_EN - when defined, each half is lengthened by
//               WAIT_CYCLES cycles; otherwise WAIT_CYCLES is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_controller
    import sram_pkg::*;
#(
    parameter int HALF_CYCLES = 2,   // cycles per half access, minimum 2
    parameter int WAIT_CYCLES = 1    // extra cycles per half (SRAM_WAIT_EN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   memReadIn,
    input  logic                   memWriteIn,
    input  logic [31:0]            addrIn,
    input  logic [31:0]            writeDataIn,
    output logic [31:0]            readDataOut,
    output logic                   readyOut,
    output logic [SRAM_ADDR_W-1:0] sramAddr,
    inout  wire  [SRAM_DATA_W-1:0] sramDq,
    output logic                   sramWeN,
    output logic                   sramUbN,
    output logic                   sramLbN,
    output logic                   sramCeN,
    output logic                   sramOeN
);

`ifdef SRAM_WAIT_EN
    localparam int c_HALF_LEN = HALF_CYCLES + WAIT_CYCLES;
`else
    // WAIT_CYCLES contributes nothing to the timing in this build.
    localparam int c_HALF_LEN = HALF_CYCLES + 0 * WAIT_CYCLES;
`endif
    localparam int               c_CNT_W = cnt_width(c_HALF_LEN);
    localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(c_HALF_LEN - 1);

    sram_state_e       r_state;
    sram_state_e       w_next;
    logic              r_write;
    logic [16:0]       r_word;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [18:0]       w_off;
    logic              w_req;
    logic              w_load;
    logic              w_dec;
    logic              w_zero;
    logic              w_busy;
    logic              w_half;
    logic              w_drive;
    logic              w_unused;

    assign w_req = memReadIn | memWriteIn;

    // Subtraction is done in 19 bits so addresses below the window wrap.
    assign w_off = addrIn[18:0] - 19'(SRAM_BASE_ADDR);

    sram_cycle_counter #(
        .WIDTH      (c_CNT_W)
    ) u_cycle_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (c_LOAD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request is captured once, on leaving IDLE; inputs are ignored after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write <= 1'b0;
            r_word  <= '0;
            r_wdata <= '0;
        end else if ((r_state == ST_IDLE) && w_req) begin
            r_write <= memWriteIn;
            r_word  <= w_off[18:2];
            r_wdata <= writeDataIn;
        end
    end

    // Read data is sampled on the final cycle of each half.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (!r_write && w_zero) begin
            if (r_state == ST_LO) begin
                r_rdata[15:0] <= sramDq;
            end else if (r_state == ST_HI) begin
                r_rdata[31:16] <= sramDq;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_dec    = 1'b0;
        readyOut = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    readyOut = 1'b0;
                    w_next   = ST_LO;
                    w_load   = 1'b1;
                end
            end
            ST_LO: begin
                readyOut = 1'b0;
                if (w_zero) begin
                    w_next = ST_HI;
                    w_load = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_HI: begin
                readyOut = 1'b0;
                if (w_zero) begin
                    w_next = ST_DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are forced safe while rst is asserted so an aborted write
    // never issues a strobe during the reset cycle.
    assign w_busy  = ((r_state == ST_LO) || (r_state == ST_HI)) && !rst;
    assign w_half  = (r_state == ST_HI);
    assign w_drive = w_busy && r_write;

    assign sramAddr = w_busy ? {r_word, w_half} : '0;
    assign sramDq   = w_drive ? (w_half ? r_wdata[31:16] : r_wdata[15:0])
                              : {SRAM_DATA_W{1'bz}};
    // The rising edge on the last cycle of each half is the write strobe.
    assign sramWeN  = ~(w_drive && !w_zero);

    assign sramUbN  = 1'b0;
    assign sramLbN  = 1'b0;
    assign sramCeN  = 1'b0;
    assign sramOeN  = 1'b0;

    assign readDataOut = r_rdata;

    assign w_unused = &{1'b0, addrIn[31:19], w_off[1:0]};

endmodule

`default_nettype wire

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter HALF_CYCLES, default 2, cycles spent on each 16-bit half access (min 2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra cycles per half, used only under SRAM_WAIT_EN.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port memReadIn  input  1  word read request from the MEM stage.
REQ-006 SHALL have port memWriteIn  input  1  word write request from the MEM stage.
REQ-007 SHALL have port addrIn  input  32  byte address, data-memory window starting at 1024.
REQ-008 SHALL have port writeDataIn  input  32  write word.
REQ-009 SHALL have port readDataOut  output  32  last completed read word.
REQ-010 SHALL have port readyOut  output  1  low = freeze pipeline; high = no access pending or access done.
REQ-011 SHALL have ports sramAddr  output  18, sramDq  inout  16, sramWeN  output  1 (active-low write enable).
REQ-012 SHALL have ports sramUbN, sramLbN, sramCeN, sramOeN  output  1 each, all tied to 0.

Function
REQ-013 SHALL implement states IDLE, LO, HI, DONE.
REQ-014 IDLE -> LO when memWriteIn or memReadIn is high; otherwise stay in IDLE.
REQ-015 LO and HI SHALL each last HALF_CYCLES cycles, counted by a down-counter; LO -> HI -> DONE; DONE -> IDLE unconditionally.
REQ-016 readyOut SHALL be combinational: 0 in IDLE with a request, 0 in LO/HI, 1 in DONE, 1 in IDLE without a request.
REQ-017 Default latency: request seen in cycle 0; readyOut low in cycles 0-4; readyOut high in cycle 5 (DONE).
REQ-018 Request in the first IDLE cycle after DONE SHALL start a new access; back-to-back accesses take 6 cycles each.
REQ-019 Address/data/op SHALL be latched on the IDLE->LO transition; later input changes SHALL be ignored until IDLE.
REQ-020 Word address w = (addrIn - 1024)[18:2]; sramAddr = {w,0} in LO, {w,1} in HI, 0 in IDLE/DONE.
REQ-021 Write: LO drives writeData[15:0], HI drives writeData[31:16] on sramDq; sramWeN is low on all but the last cycle of each half, high on that last cycle.
REQ-022 sramDq SHALL be high-Z except during write LO/HI; sramWeN SHALL be high outside write LO/HI.
REQ-023 Read: sramDq SHALL be sampled on the last LO cycle into readDataOut[15:0] and on the last HI cycle into readDataOut[31:16].
REQ-024 readDataOut SHALL hold its value until the next read completes; writes SHALL not alter it.
REQ-025 memReadIn and memWriteIn both high SHALL be treated as a write.
REQ-026 addrIn below 1024 SHALL wrap modulo 2^19 in the subtraction; no error is flagged.

Reset
REQ-027 rst SHALL force state IDLE, counter 0, readDataOut 0, sramWeN 1, sramDq high-Z, sramAddr 0, at any state including mid-access.
REQ-028 An aborted access SHALL not complete; a request still asserted after rst deasserts SHALL start from LO with a full latency.

Configuration
REQ-029 With SRAM_WAIT_EN defined, each half SHALL last HALF_CYCLES+WAIT_CYCLES cycles; sramWeN stays high only on the final cycle of each half.
REQ-030 Without SRAM_WAIT_EN, WAIT_CYCLES SHALL have no effect and latency SHALL be as in REQ-017.

Structure
REQ-031 Package sram_pkg SHALL hold the state encoding, SRAM_BASE_ADDR = 1024, SRAM_ADDR_W = 18 and SRAM_DATA_W = 16.
REQ-032 The down-counter SHALL be the sub-module sram_cycle_counter (load, decrement, zero flag).

Verification
REQ-033 Write 0xDEADBEEF to 1024 -> sramAddr 0 gets 0xBEEF, then sramAddr 1 gets 0xDEAD; readyOut low 5 cycles, high in cycle 5.
REQ-034 Read 1024 after REQ-033 with an SRAM model -> readDataOut = 0xDEADBEEF in DONE; held through a following write to 1028.
REQ-035 Write 0x12345678 to 1028 -> sramAddr 2 = 0x5678, sramAddr 3 = 0x1234; sramWeN high on each half's last cycle.
REQ-036 rst in cycle 2 of a write to 1032 -> IDLE next cycle, sramWeN 1, sramDq Z; SRAM addr 4/5 unchanged if the write strobe was not yet issued.
REQ-037 Back-to-back reads of 1024 and 1028 -> readyOut high only in cycles 5 and 11.
REQ-038 SRAM_WAIT_EN with WAIT_CYCLES=1 -> readyOut low cycles 0-6, high in cycle 7.
